// File: rtl/pe_array_writeback.sv
// Purpose     : drains PE-array result beats through a 2-entry FIFO into the output
//               buffer memory as full-width words at contiguous addresses from base_addr.
// Latency     : a beat accepted in cycle t is presented on wr_data in cycle t+1 at the earliest.
// Backpressure: wr_ready=0 holds wr_en/wr_addr/wr_data stable; in_ready drops once 2 beats are held.
// Ports       : start/base_addr/row_length/num_rows configure a pass; in_valid/in_ready/
//               output_bus1_PEA is the beat input; wr_en/wr_ready/wr_addr/wr_data is the memory
//               write port; row_done/busy/done/protocol_err report progress and misuse.
// Option      : define PE_WB_STALL_CNT_EN to add stall_cycles (write-stall cycle counter).
`ifndef N_PE
`define N_PE 4
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 8
`endif
`ifndef ADDR_FIFO
`define ADDR_FIFO 8
`endif

module pe_array_writeback #(
  parameter int N_PE        = `N_PE,
  parameter int WID_PE_BITS = `WID_PE_BITS,
  parameter int ADDR_FIFO   = `ADDR_FIFO,
  parameter int ADDR_MEM    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_MEM-1:0]         base_addr,
  input  logic [ADDR_FIFO-1:0]        row_length,
  input  logic [ADDR_FIFO-1:0]        num_rows,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WID_PE_BITS*N_PE-1:0] output_bus1_PEA,
  output logic                        wr_en,
  input  logic                        wr_ready,
  output logic [ADDR_MEM-1:0]         wr_addr,
  output logic [WID_PE_BITS*N_PE-1:0] wr_data,
  output logic                        row_done,
  output logic                        busy,
  output logic                        done,
`ifdef PE_WB_STALL_CNT_EN
  output logic [31:0]                 stall_cycles,
`endif
  output logic                        protocol_err
);

  localparam int DW = WID_PE_BITS * N_PE;
  localparam int CW = 2 * ADDR_FIFO;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q;
  logic [DW-1:0]        mem_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           cnt_q;
  logic [ADDR_MEM-1:0]  addr_q;
  logic [ADDR_FIFO-1:0] rowlen_q, col_q;
  logic [CW-1:0]        total_q, beat_q;
  logic                 last_q;
  logic                 row_done_q;
  logic                 protocol_err_q;

  logic start_ok, cfg_zero, push, pop, last_beat;

  assign start_ok  = start && (state_q == S_IDLE);
  assign cfg_zero  = (row_length == '0) || (num_rows == '0);
  assign in_ready  = (state_q == S_RUN) && (cnt_q < 2'd2) && !last_q;
  assign push      = in_valid && in_ready;
  assign wr_en     = (cnt_q != 2'd0);
  assign pop       = wr_en && wr_ready;
  // total_q is at least 1 whenever beats are being accepted
  assign last_beat = push && (beat_q == total_q - CW'(1));

  assign wr_addr      = addr_q;
  assign wr_data      = mem_q[rd_ptr_q];
  assign row_done     = row_done_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign protocol_err = protocol_err_q;

  // Pass sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= cfg_zero ? S_DONE : S_RUN;
        S_RUN:   if (last_beat) state_q <= S_DRAIN;
        // the final beat always lands in the FIFO before DRAIN, so count==1 on its pop
        S_DRAIN: if (pop && (cnt_q == 2'd1)) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-entry FIFO; simultaneous push/pop at count 1 keeps the count and the order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= output_bus1_PEA;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Config capture, beat counting, write addressing and row tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rowlen_q   <= '0;
      total_q    <= '0;
      beat_q     <= '0;
      col_q      <= '0;
      last_q     <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      if (start_ok) begin
        addr_q   <= base_addr;
        rowlen_q <= row_length;
        total_q  <= CW'(row_length) * CW'(num_rows);
        beat_q   <= '0;
        col_q    <= '0;
        last_q   <= 1'b0;
      end else begin
        if (push) begin
          beat_q <= beat_q + CW'(1);
          if (last_beat) last_q <= 1'b1;
        end
        if (pop) begin
          addr_q <= addr_q + ADDR_MEM'(1);
          if (col_q == rowlen_q - ADDR_FIFO'(1)) begin
            col_q      <= '0;
            row_done_q <= 1'b1;
          end else begin
            col_q <= col_q + ADDR_FIFO'(1);
          end
        end
      end
    end
  end

  // Sticky misuse flag; a beat offered outside RUN wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err_q <= 1'b0;
    end else if (in_valid && (state_q != S_RUN)) begin
      protocol_err_q <= 1'b1;
    end else if (start_ok) begin
      protocol_err_q <= 1'b0;
    end
  end

`ifdef PE_WB_STALL_CNT_EN
  logic [31:0] stall_q;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (wr_en && !wr_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_writeback.sv
// Purpose     : self-checking bench for pe_array_writeback (pass table + corner sequences).
// Latency     : reference model tracks accepted vs written beats; outputs sampled 1 time unit after negedge.
// Backpressure: wr_ready driven always-high, in fixed stall windows, or randomly.
module tb_pe_array_writeback;

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  rl;
    logic [7:0]  nr;
    int          vmode;     // 0: in_valid always when allowed, 1: random + stray starts
    int          rmode;     // 0: ready always, 1: stall window, 2: random
    int          sa;
    int          sl;
    int          exp_writes;
    logic [15:0] exp_last;
    int          exp_stall; // -1: not predicted by the table
  } vec_t;

  logic        clk, rst_n, start, in_valid, in_ready, wr_en, wr_ready;
  logic        row_done, busy, done, protocol_err;
  logic [15:0] base_addr, wr_addr;
  logic [7:0]  row_length, num_rows;
  logic [31:0] output_bus1_PEA, wr_data;
`ifdef PE_WB_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pe_array_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_length(row_length), .num_rows(num_rows), .in_valid(in_valid),
    .in_ready(in_ready), .output_bus1_PEA(output_bus1_PEA), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .row_done(row_done), .busy(busy), .done(done),
`ifdef PE_WB_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass is "accepted beats" vs "written beats"; data is an ordered list
  bit          mon_en = 1'b0;
  int          m_phase, m_acc, m_wr, m_total, m_rl, outst, old_phase;
  logic [15:0] m_base, exp_addr, prev_addr, last_addr_seen;
  logic [31:0] prev_data, m_stall;
  logic [31:0] m_dq[$];
  bit          m_rd, m_perr, e_ir, e_we, fire_w, fire_a, hold_prev;
  int          n_wr_seen, done_cnt;

  task automatic model_reset();
    m_phase = P_IDLE; m_acc = 0; m_wr = 0; m_total = 0; m_rl = 1;
    m_base = '0; m_stall = '0; m_rd = 1'b0; m_perr = 1'b0; hold_prev = 1'b0;
    m_dq.delete();
  endtask

  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      outst = m_acc - m_wr;
      e_ir  = (m_phase == P_RUN) && (outst < 2);
      e_we  = (outst != 0);
      chk("in_ready", 64'(in_ready), 64'(e_ir));
      chk("wr_en", 64'(wr_en), 64'(e_we));
      chk("busy", 64'(busy), 64'(m_phase == P_RUN || m_phase == P_DRAIN));
      chk("done", 64'(done), 64'(m_phase == P_DONE));
      chk("row_done", 64'(row_done), 64'(m_rd));
      chk("protocol_err", 64'(protocol_err), 64'(m_perr));
`ifdef PE_WB_STALL_CNT_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
      if (hold_prev) begin
        chk("hold_addr", 64'(wr_addr), 64'(prev_addr));
        chk("hold_data", 64'(wr_data), 64'(prev_data));
      end
      fire_w = e_we && wr_ready;
      fire_a = e_ir && in_valid;
      if (fire_w) begin
        exp_addr = m_base + 16'(m_wr);
        chk("wr_addr", 64'(wr_addr), 64'(exp_addr));
        chk("wr_data", 64'(wr_data), 64'(m_dq[m_wr]));
        n_wr_seen++;
        last_addr_seen = wr_addr;
      end
      hold_prev = e_we && !wr_ready;
      prev_addr = wr_addr;
      prev_data = wr_data;
      if (done) done_cnt++;

      // advance the model across the coming clock edge
      old_phase = m_phase;
      m_rd = 1'b0;
      if (e_we && !wr_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (fire_w) begin
        m_wr++;
        if (m_wr % m_rl == 0) m_rd = 1'b1;
      end
      if (fire_a) begin
        m_dq.push_back(output_bus1_PEA);
        m_acc++;
      end
      if (old_phase == P_IDLE && start) begin
        m_perr  = 1'b0;
        m_base  = base_addr;
        m_rl    = (row_length == 0) ? 1 : int'(row_length);
        m_total = int'(row_length) * int'(num_rows);
        m_acc = 0; m_wr = 0; m_stall = '0; hold_prev = 1'b0;
        m_dq.delete();
        m_phase = (m_total == 0) ? P_DONE : P_RUN;
      end else if (old_phase == P_RUN && m_acc == m_total) begin
        m_phase = P_DRAIN;
      end else if (old_phase == P_DRAIN && m_wr == m_total) begin
        m_phase = P_DONE;
      end else if (old_phase == P_DONE) begin
        m_phase = P_IDLE;
      end
      if (in_valid && old_phase != P_RUN) m_perr = 1'b1;
    end
  end

  task automatic run_pass(input vec_t v);
    bit fin;
    fin = 1'b0;
    @(negedge clk);
    base_addr = v.base; row_length = v.rl; num_rows = v.nr;
    start = 1'b1; in_valid = 1'b0; wr_ready = 1'b1;
    n_wr_seen = 0; done_cnt = 0;
    for (int c = 1; c < 400 && !fin; c++) begin
      @(negedge clk);
      start = (v.vmode == 1) && (m_phase == P_RUN || m_phase == P_DRAIN) &&
              ($urandom_range(0, 7) == 0);
      if (c == 1) begin
        base_addr = 16'($urandom); row_length = 8'($urandom); num_rows = 8'($urandom);
      end
      in_valid = (m_phase == P_RUN) && ((v.vmode == 0) || ($urandom_range(0, 1) == 1));
      output_bus1_PEA = $urandom;
      case (v.rmode)
        1:       wr_ready = !(c >= v.sa && c < v.sa + v.sl);
        2:       wr_ready = ($urandom_range(0, 9) < 6);
        default: wr_ready = 1'b1;
      endcase
      #2;
      if (done_cnt != 0) fin = 1'b1;
    end
    chk("pass_finished", 64'(fin), 64'(1));
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("tbl_writes", 64'(n_wr_seen), 64'(v.exp_writes));
    if (v.exp_writes > 0) chk("tbl_last_addr", 64'(last_addr_seen), 64'(v.exp_last));
    chk("tbl_done_pulses", 64'(done_cnt), 64'(1));
`ifdef PE_WB_STALL_CNT_EN
    if (v.exp_stall >= 0) chk("tbl_stall_cycles", 64'(stall_cycles), 64'(v.exp_stall));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    vec_t pv;
    vecs[0] = '{base:16'h0100, rl:8'd4, nr:8'd2, vmode:0, rmode:0, sa:0, sl:0,
                exp_writes:8, exp_last:16'h0107, exp_stall:0};
    vecs[1] = '{base:16'h0100, rl:8'd4, nr:8'd2, vmode:0, rmode:1, sa:3, sl:5,
                exp_writes:8, exp_last:16'h0107, exp_stall:5};
    vecs[2] = '{base:16'hFFFE, rl:8'd4, nr:8'd1, vmode:0, rmode:0, sa:0, sl:0,
                exp_writes:4, exp_last:16'h0001, exp_stall:0};
    vecs[3] = '{base:16'h0000, rl:8'd3, nr:8'd0, vmode:0, rmode:0, sa:0, sl:0,
                exp_writes:0, exp_last:16'h0000, exp_stall:0};
    vecs[4] = '{base:16'h0020, rl:8'd0, nr:8'd5, vmode:0, rmode:0, sa:0, sl:0,
                exp_writes:0, exp_last:16'h0000, exp_stall:0};
    vecs[5] = '{base:16'h1234, rl:8'd1, nr:8'd3, vmode:1, rmode:2, sa:0, sl:0,
                exp_writes:3, exp_last:16'h1236, exp_stall:-1};
    vecs[6] = '{base:16'h00F0, rl:8'd5, nr:8'd3, vmode:1, rmode:2, sa:0, sl:0,
                exp_writes:15, exp_last:16'h00FE, exp_stall:-1};
    for (int i = 7; i < 10; i++) begin
      vecs[i].base  = 16'($urandom);
      vecs[i].rl    = 8'($urandom_range(1, 5));
      vecs[i].nr    = 8'($urandom_range(0, 3));
      vecs[i].vmode = 1; vecs[i].rmode = 2; vecs[i].sa = 0; vecs[i].sl = 0;
      vecs[i].exp_writes = int'(vecs[i].rl) * int'(vecs[i].nr);
      vecs[i].exp_last   = vecs[i].base + 16'(vecs[i].exp_writes - 1);
      vecs[i].exp_stall  = -1;
    end

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    base_addr = '0; row_length = '0; num_rows = '0; output_bus1_PEA = '0;
    n_wr_seen = 0; done_cnt = 0; last_addr_seen = '0;
    model_reset();
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_busy_done", 64'({busy, done, row_done}), 64'(0));
    chk("rst_protocol_err", 64'(protocol_err), 64'(0));
`ifdef PE_WB_STALL_CNT_EN
    chk("rst_stall_cycles", 64'(stall_cycles), 64'(0));
`endif
    #11 rst_n = 1'b1;
    mon_en = 1'b1;

    // beat offered while idle: flag sets, nothing is written, next start clears it
    @(negedge clk); in_valid = 1'b1; output_bus1_PEA = 32'hDEAD_BEEF;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    #2;
    chk("perr_set", 64'(protocol_err), 64'(1));
    chk("perr_no_write", 64'(n_wr_seen), 64'(0));
    pv = '{base:16'h0040, rl:8'd2, nr:8'd2, vmode:0, rmode:0, sa:0, sl:0,
           exp_writes:4, exp_last:16'h0043, exp_stall:0};
    run_pass(pv);
    chk("perr_cleared", 64'(protocol_err), 64'(0));

    for (int i = 0; i < 10; i++) run_pass(vecs[i]);

    // asynchronous reset in the middle of a pass, then a clean full pass
    @(negedge clk);
    base_addr = 16'h0100; row_length = 8'd4; num_rows = 8'd2;
    start = 1'b1; in_valid = 1'b0; wr_ready = 1'b1; n_wr_seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (m_phase == P_RUN);
      output_bus1_PEA = $urandom;
      #2;
      if (n_wr_seen >= 3) break;
    end
    chk("rst_mid_writes_before", 64'(n_wr_seen), 64'(3));
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("amid_in_ready", 64'(in_ready), 64'(0));
    chk("amid_wr_en", 64'(wr_en), 64'(0));
    chk("amid_wr_addr", 64'(wr_addr), 64'(0));
    chk("amid_wr_data", 64'(wr_data), 64'(0));
    chk("amid_busy", 64'(busy), 64'(0));
    chk("amid_done_rowdone", 64'({done, row_done}), 64'(0));
    chk("amid_protocol_err", 64'(protocol_err), 64'(0));
    in_valid = 1'b0; wr_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;
    run_pass(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
